// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the byte SRAM arbiter.
// State enum, lane count, sel-mask helpers, out-of-range read pattern.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DBG_BYTE,
    S_DBG_LAST,
    S_DBG_ACK
  } state_e;

  localparam int LANES = 4;

  localparam logic [31:0] DEADBEEF = 32'hDEADBEEF;

  // Isolate the lowest set lane of a sel mask (one-hot or zero).
  function automatic logic [LANES-1:0] sel_low_bit(
    input logic [LANES-1:0] m
  );
    return m & (~m + LANES'(1));
  endfunction

  // Remove the lowest set lane from a sel mask.
  function automatic logic [LANES-1:0] sel_clr_low(
    input logic [LANES-1:0] m
  );
    return m & (m - LANES'(1));
  endfunction

endpackage

// File: rtl/sram_arb_lane_seq.sv
// Remaining-lane tracker for split Wishbone word accesses.
// Ports: clk/rst_n, i_load+i_sel (new mask), i_step, i_clr; o_lane, o_last, o_any.
module sram_arb_lane_seq
  import sram_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [LANES-1:0] i_sel,
  input  logic             i_step,
  input  logic             i_clr,
  output logic [1:0]       o_lane,
  output logic             o_last,
  output logic             o_any
);

  logic [LANES-1:0] mask_q;
  logic [LANES-1:0] mask_d;
  logic [LANES-1:0] src;
  logic [LANES-1:0] low;
  logic [LANES-1:0] rest;

  // A load presents the incoming sel immediately so the first
  // byte can be issued in the same cycle the word is accepted.
  always_comb begin
    src    = i_load ? i_sel : mask_q;
    low    = sel_low_bit(src);
    rest   = sel_clr_low(src);
    o_any  = |src;
    o_last = o_any && (rest == '0);
    o_lane = 2'd0;
    unique case (1'b1)
      low[1]:  o_lane = 2'd1;
      low[2]:  o_lane = 2'd2;
      low[3]:  o_lane = 2'd3;
      default: o_lane = 2'd0;
    endcase
  end

  always_comb begin
    mask_d = mask_q;
    if (i_clr) begin
      mask_d = '0;
    end else if (i_load || i_step) begin
      mask_d = rest;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates a 512x8 SRAM between the core byte port and a 32-bit
// Wishbone debug port that is split into per-lane byte accesses.
// Ports: wb_clk_i/wb_rst_ni; core i_c_*/o_c_*; Wishbone i_wb_*/o_wb_*;
// SRAM o_sram_*/i_sram_rdata (read data one cycle after ren).
// Build option: SRAM_ARB_RANGE_CHK_EN rejects debug adr >= MEMSIZE
// with a one-cycle ack and 32'hDEADBEEF; otherwise the address wraps.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int MEMSIZE    = 512,
  parameter int AW         = 9,
  parameter int STARVE_LIM = 16
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic [AW-1:0] i_c_raddr,
  input  logic          i_c_ren,
  input  logic [AW-1:0] i_c_waddr,
  input  logic [7:0]    i_c_wdata,
  input  logic          i_c_wen,
  output logic          o_c_gnt,
  output logic [7:0]    o_c_rdata,
  output logic          o_c_rvalid,
  input  logic [31:0]   i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic [AW-1:0] o_sram_raddr,
  output logic          o_sram_ren,
  output logic [AW-1:0] o_sram_waddr,
  output logic [7:0]    o_sram_wdata,
  output logic          o_sram_wen,
  input  logic [7:0]    i_sram_rdata
);

  localparam int SW = $clog2(STARVE_LIM + 1);

  logic [1:0] rsync_q;
  logic [1:0] rsync_d;
  logic       rst_n;

  state_e          state_q, state_d;
  logic [AW-3:0]   base_q, base_d;
  logic [31:0]     dat_q, dat_d;
  logic            we_q, we_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [31:0]     buf_q, buf_d;
  logic [31:0]     rdt_q, rdt_d;
  logic            pend_q, pend_d;
  logic [1:0]      pend_lane_q, pend_lane_d;
  logic            crv_q, crv_d;

  logic            dbg_req;
  logic            c_req;
  logic            force_dbg;
  logic            oor;
  logic [3:0]      sel_in;
  logic            dbg_start;
  logic            seq_step;
  logic            seq_clr;
  logic [1:0]      seq_lane;
  logic            seq_last;
  logic            seq_any;
  logic            dbg_go;
  logic            core_go;
  logic [AW-3:0]   a_base;
  logic [31:0]     a_dat;
  logic            a_we;
  logic            unused_adr;

  // Async assert, sync release; the released reset also gates the
  // combinational grant/enable paths so outputs stay 0 until then.
  always_comb rsync_d = {rsync_q[0], 1'b1};

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rsync_q <= '0;
    end else begin
      rsync_q <= rsync_d;
    end
  end

  assign rst_n = rsync_q[1];

  assign dbg_req   = i_wb_cyc & i_wb_stb;
  assign c_req     = i_c_ren | i_c_wen;
  assign force_dbg = (starve_q == SW'(STARVE_LIM));

`ifdef SRAM_ARB_RANGE_CHK_EN
  assign oor = (i_wb_adr >= 32'(MEMSIZE));
`else
  localparam int unused_memsize = MEMSIZE;
  assign oor = 1'b0;
`endif

  assign unused_adr = ^{i_wb_adr[31:AW], i_wb_adr[1:0]};

  assign sel_in    = oor ? 4'b0000 : i_wb_sel;
  assign dbg_start = rst_n && (state_q == S_IDLE) && dbg_req
                     && (!c_req || force_dbg);

  sram_arb_lane_seq u_lane_seq (
    .clk    (wb_clk_i),
    .rst_n  (rst_n),
    .i_load (dbg_start),
    .i_sel  (sel_in),
    .i_step (seq_step),
    .i_clr  (seq_clr),
    .o_lane (seq_lane),
    .o_last (seq_last),
    .o_any  (seq_any)
  );

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    dat_d        = dat_q;
    we_d         = we_q;
    starve_d     = starve_q;
    buf_d        = buf_q;
    rdt_d        = rdt_q;
    pend_d       = 1'b0;
    pend_lane_d  = pend_lane_q;
    crv_d        = 1'b0;
    seq_step     = 1'b0;
    seq_clr      = 1'b0;
    dbg_go       = 1'b0;
    core_go      = 1'b0;
    a_base       = base_q;
    a_dat        = dat_q;
    a_we         = we_q;
    o_c_gnt      = 1'b0;
    o_sram_raddr = '0;
    o_sram_ren   = 1'b0;
    o_sram_waddr = '0;
    o_sram_wdata = '0;
    o_sram_wen   = 1'b0;

    // Byte returned for the debug read issued last cycle.
    if (pend_q) begin
      buf_d[8*pend_lane_q +: 8] = i_sram_rdata;
    end

    if (rst_n) begin
      unique case (state_q)
        S_IDLE: begin
          if (dbg_start) begin
            starve_d = '0;
            base_d   = i_wb_adr[AW-1:2];
            dat_d    = i_wb_dat;
            we_d     = i_wb_we;
            buf_d    = '0;
            a_base   = i_wb_adr[AW-1:2];
            a_dat    = i_wb_dat;
            a_we     = i_wb_we;
            if (oor) begin
              rdt_d   = DEADBEEF;
              state_d = S_DBG_ACK;
            end else if (!seq_any) begin
              rdt_d   = '0;
              state_d = S_DBG_ACK;
            end else begin
              dbg_go = 1'b1;
            end
          end else begin
            core_go  = 1'b1;
            starve_d = dbg_req ? starve_q + SW'(1) : '0;
          end
        end
        S_DBG_BYTE: begin
          if (!i_wb_cyc) begin
            seq_clr = 1'b1;
            state_d = S_IDLE;
          end else begin
            dbg_go   = 1'b1;
            seq_step = 1'b1;
          end
        end
        S_DBG_LAST: begin
          if (!i_wb_cyc) begin
            state_d = S_IDLE;
          end else begin
            rdt_d   = buf_d;
            state_d = S_DBG_ACK;
          end
        end
        S_DBG_ACK: begin
          core_go = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (dbg_go) begin
      if (a_we) begin
        o_sram_wen   = 1'b1;
        o_sram_waddr = {a_base, seq_lane};
        o_sram_wdata = a_dat[8*seq_lane +: 8];
      end else begin
        o_sram_ren   = 1'b1;
        o_sram_raddr = {a_base, seq_lane};
        pend_d       = 1'b1;
        pend_lane_d  = seq_lane;
      end
      if (seq_last) begin
        state_d = a_we ? S_DBG_ACK : S_DBG_LAST;
      end else begin
        state_d = S_DBG_BYTE;
      end
    end

    if (core_go && c_req) begin
      o_c_gnt      = 1'b1;
      o_sram_ren   = i_c_ren;
      o_sram_raddr = i_c_raddr;
      o_sram_wen   = i_c_wen;
      o_sram_waddr = i_c_waddr;
      o_sram_wdata = i_c_wdata;
      crv_d        = i_c_ren;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      starve_q    <= '0;
      buf_q       <= '0;
      rdt_q       <= '0;
      pend_q      <= 1'b0;
      pend_lane_q <= '0;
      crv_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      starve_q    <= starve_d;
      buf_q       <= buf_d;
      rdt_q       <= rdt_d;
      pend_q      <= pend_d;
      pend_lane_q <= pend_lane_d;
      crv_q       <= crv_d;
    end
  end

  assign o_c_rvalid = crv_q;
  assign o_c_rdata  = crv_q ? i_sram_rdata : 8'h00;
  assign o_wb_ack   = (state_q == S_DBG_ACK);
  assign o_wb_rdt   = rdt_q;

endmodule
